staller: RTL and testbench

- Pipeline hazard unit for the 4-bit-opcode pipelined processor.
- Looks at the opcode in Decode (op_D) and the opcode in Execute (op_E).
- Requests a bubble (noop) for memory and control-flow instructions.
- Issues a registered full-pipeline squash (full_noop) the cycle after a control-flow instruction leaves Execute.
- Sits beside the D/E pipeline registers; the bubble logic has no pipeline state of its own.

---
 rtl/staller_pkg.sv | 17 +
 rtl/staller_opdecode.sv | 21 ++
 rtl/staller.sv | 94 +++++++++
 tb/tb_staller.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/staller_pkg.sv
// staller_pkg: shared opcode definitions for the pipeline hazard unit.
//   OP_W     - opcode field width
//   OP_LW    - load word
//   OP_SW    - store word
//   OP_BCOND - conditional branch
//   OP_JAL   - jump and link
// Used by staller_opdecode and staller.
package staller_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_LW    = 4'b0111;
  localparam logic [OP_W-1:0] OP_SW    = 4'b0011;
  localparam logic [OP_W-1:0] OP_BCOND = 4'b0010;
  localparam logic [OP_W-1:0] OP_JAL   = 4'b0110;

endpackage : staller_pkg

// File: rtl/staller_opdecode.sv
// staller_opdecode: classifies one opcode for hazard purposes.
// Purely combinational.
//   op      in  W  opcode to classify
//   is_mem  out 1  opcode is LW or SW
//   is_ctrl out 1  opcode is BCOND or JAL
module staller_opdecode
  import staller_pkg::*;
#(
  parameter int W = OP_W
) (
  input  logic [W-1:0] op,
  output logic         is_mem,
  output logic         is_ctrl
);

  always_comb begin
    is_mem  = (op == W'(OP_LW))    || (op == W'(OP_SW));
    is_ctrl = (op == W'(OP_BCOND)) || (op == W'(OP_JAL));
  end

endmodule : staller_opdecode

// File: rtl/staller.sv
// staller: pipeline hazard unit sitting beside the D/E pipeline registers.
//   clk         in  1        pipeline clock, rising edge
//   reset       in  1        asynchronous active-high reset
//   op_D        in  REGBITS  opcode in Decode
//   op_E        in  REGBITS  opcode in Execute
//   noop        out 1        combinational bubble request for D/E this cycle
//   full_noop   out 1        registered squash of all front-end stages
//   stall_count out 16       (only with STALLER_STATS_EN) saturating count of
//                            cycles with noop asserted
// Optional feature macro: STALLER_STATS_EN.
module staller
  import staller_pkg::*;
#(
  parameter int REGBITS = OP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REGBITS-1:0] op_D,
  input  logic [REGBITS-1:0] op_E,
  output logic               noop,
  output logic               full_noop
`ifdef STALLER_STATS_EN
  ,
  output logic [15:0]        stall_count
`endif
);

  logic d_is_mem;
  logic d_is_ctrl;
  logic e_is_mem;
  logic e_is_ctrl;

  staller_opdecode #(.W(REGBITS)) u_dec_d (
    .op      (op_D),
    .is_mem  (d_is_mem),
    .is_ctrl (d_is_ctrl)
  );

  staller_opdecode #(.W(REGBITS)) u_dec_e (
    .op      (op_E),
    .is_mem  (e_is_mem),
    .is_ctrl (e_is_ctrl)
  );

  // A memory op in E has already been bubbled while it sat in D, so only
  // control flow in E keeps holding the bubble.
  logic e_is_mem_unused;
  assign e_is_mem_unused = e_is_mem;

  always_comb begin
    noop = d_is_mem || d_is_ctrl || e_is_ctrl;
  end

  // Squash lands the cycle after a branch/jump resolves in E.
  logic full_noop_q;
  logic full_noop_d;

  always_comb begin
    full_noop_d = e_is_ctrl;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_noop_q <= 1'b0;
    end else begin
      full_noop_q <= full_noop_d;
    end
  end

  assign full_noop = full_noop_q;

`ifdef STALLER_STATS_EN
  logic [15:0] stall_count_q;
  logic [15:0] stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (noop && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule : staller

// File: tb/tb_staller.sv
// tb_staller: table-driven and randomized check of the staller hazard unit.
module tb_staller;

  logic       clk;
  logic       reset;
  logic [3:0] op_D;
  logic [3:0] op_E;
  logic       noop;
  logic       full_noop;
`ifdef STALLER_STATS_EN
  logic [15:0] stall_count;
`endif

  int vectors;
  int miscompares;

  staller #(.REGBITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_D      (op_D),
    .op_E      (op_E),
    .noop      (noop),
    .full_noop (full_noop)
`ifdef STALLER_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rules stated as opcode sets.
  function automatic bit hazard_d(input logic [3:0] o);
    return o inside {4'b0111, 4'b0011, 4'b0010, 4'b0110};
  endfunction

  function automatic bit hazard_e(input logic [3:0] o);
    return o inside {4'b0010, 4'b0110};
  endfunction

  function automatic bit want_bubble(input logic [3:0] d, input logic [3:0] e);
    return hazard_d(d) || hazard_e(e);
  endfunction

  // Saturating count of clock edges seen with a bubble requested.
  int unsigned count_m;
  always @(posedge clk or posedge reset) begin
    if (reset) count_m <= 0;
    else if (want_bubble(op_D, op_E) && count_m < 65535) count_m <= count_m + 1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic check_count(input string name);
`ifdef STALLER_STATS_EN
    check(name, stall_count, count_m[15:0]);
`endif
  endtask

  typedef struct {
    logic [3:0] d;
    logic [3:0] e;
    logic       exp_noop;
    logic       exp_full;
  } vec_t;

  vec_t tbl[12];

  initial begin
    vectors     = 0;
    miscompares = 0;

    tbl[0]  = '{4'b0111, 4'b0000, 1'b1, 1'b0};
    tbl[1]  = '{4'b0000, 4'b0111, 1'b0, 1'b0};
    tbl[2]  = '{4'b0011, 4'b0000, 1'b1, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0011, 1'b0, 1'b0};
    tbl[4]  = '{4'b0010, 4'b0000, 1'b1, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0010, 1'b1, 1'b1};
    tbl[6]  = '{4'b0110, 4'b0000, 1'b1, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0110, 1'b1, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[9]  = '{4'b0111, 4'b0010, 1'b1, 1'b1};
    tbl[10] = '{4'b0000, 4'b0110, 1'b1, 1'b1};
    tbl[11] = '{4'b1111, 4'b1000, 1'b0, 1'b0};

    // Reset state.
    reset = 1'b1;
    op_D  = 4'b0000;
    op_E  = 4'b0000;
    #1;
    check("reset_full_noop", {15'd0, full_noop}, 16'd0);
    check_count("reset_count");
    @(negedge clk);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      op_D = tbl[i].d;
      op_E = tbl[i].e;
      #1;
      check($sformatf("tbl%0d_noop d=%b e=%b", i, tbl[i].d, tbl[i].e),
            {15'd0, noop}, {15'd0, tbl[i].exp_noop});
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_full_noop", i), {15'd0, full_noop}, {15'd0, tbl[i].exp_full});
      check_count($sformatf("tbl%0d_count", i));
    end

    // Async reset mid-cycle while full_noop is high; noop keeps following inputs.
    @(negedge clk);
    op_D = 4'b0000;
    op_E = 4'b0010;
    @(posedge clk);
    #1;
    check("pre_reset_full_noop", {15'd0, full_noop}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_full_noop", {15'd0, full_noop}, 16'd0);
    check("noop_during_reset", {15'd0, noop}, 16'd1);
    check_count("async_reset_count");
    @(posedge clk);
    #1;
    check("held_reset_full_noop", {15'd0, full_noop}, 16'd0);

    // Deassert mid-cycle: stays 0 until the next edge, then samples op_E.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_release_full_noop", {15'd0, full_noop}, 16'd0);
    @(posedge clk);
    #1;
    check("first_edge_full_noop", {15'd0, full_noop}, 16'd1);
    check_count("first_edge_count");

    // Randomized traffic, biased toward hazard opcodes.
    begin
      logic [3:0] pool [6];
      logic [3:0] prev_e;
      pool[0] = 4'b0111; pool[1] = 4'b0011; pool[2] = 4'b0010;
      pool[3] = 4'b0110; pool[4] = 4'b0000; pool[5] = 4'b0001;
      prev_e = op_E;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        // full_noop reflects the op_E that sat in E at the previous edge.
        check($sformatf("rnd%0d_full_noop", n), {15'd0, full_noop}, {15'd0, hazard_e(prev_e)});
        op_D = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : 4'($urandom);
        op_E = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : 4'($urandom);
        #1;
        check($sformatf("rnd%0d_noop d=%b e=%b", n, op_D, op_E),
              {15'd0, noop}, {15'd0, want_bubble(op_D, op_E)});
        prev_e = op_E;
        @(posedge clk);
        #1;
        check_count($sformatf("rnd%0d_count", n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_staller
